// File: rtl/systolic_pkg.sv
// Shared definitions for the 2x2 systolic array controller.
// Holds the controller state encoding, the feed length and the bit-position
// indices of each element inside a packed 2x2 matrix word
// (element [i][k] sits at slot 2*i+k, each slot data_width bits wide).
package systolic_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StFeed,
    StDrain,
    StOut
  } state_e;

  localparam int unsigned FEED_CYCLES = 3;

  // Slot numbers of the four elements in a packed matrix word.
  localparam int unsigned IDX_00 = 0;
  localparam int unsigned IDX_01 = 1;
  localparam int unsigned IDX_10 = 2;
  localparam int unsigned IDX_11 = 3;

endpackage

// File: rtl/systolic_2x2_ctrl_if.sv
// Job/result handshake bundle for systolic_2x2_ctrl.
//   in_valid/in_ready/a_mat/b_mat : job offer (source -> controller)
//   out_valid/out_ready/c00..c11/err : result delivery (controller -> consumer)
// master : job source and result consumer
// slave  : the controller
interface systolic_2x2_ctrl_if #(
  parameter int unsigned data_width = 8
);
  logic                      in_valid;
  logic                      in_ready;
  logic [4*data_width-1:0]   a_mat;
  logic [4*data_width-1:0]   b_mat;
  logic                      out_valid;
  logic                      out_ready;
  logic                      err;
  logic [2*data_width-1:0]   c00;
  logic [2*data_width-1:0]   c01;
  logic [2*data_width-1:0]   c10;
  logic [2*data_width-1:0]   c11;

  modport master (
    output in_valid, a_mat, b_mat, out_ready,
    input  in_ready, out_valid, err, c00, c01, c10, c11
  );

  modport slave (
    input  in_valid, a_mat, b_mat, out_ready,
    output in_ready, out_valid, err, c00, c01, c10, c11
  );
endinterface

// File: rtl/systolic_2x2_ctrl.sv
// Controller for a 2x2 output-stationary systolic array.
// Accepts a job (A, B), clears the array accumulators for one cycle, feeds
// skewed operands for three cycles, waits in DRAIN for the array's done flag
// (ignored in the first DRAIN cycle), captures the four results and holds
// them until the consumer accepts.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   bus (slave)       : job handshake in, result handshake out
//   sa_a0/a1, sa_b0/b1: registered skewed operands to the array
//   sa_enable, sa_clr : array enable, one-cycle accumulator clear
//   arr_done, arr_c** : array completion flag and results
// Optional feature: define SYSTOLIC_CTRL_TIMEOUT_EN to build a DRAIN watchdog
// of timeout_cycles cycles that forces capture with err=1. Without it err=0.
module systolic_2x2_ctrl
  import systolic_pkg::*;
#(
  parameter int unsigned data_width     = 8,
  parameter int unsigned timeout_cycles = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  systolic_2x2_ctrl_if.slave      bus,
  output logic [data_width-1:0]   sa_a0,
  output logic [data_width-1:0]   sa_a1,
  output logic [data_width-1:0]   sa_b0,
  output logic [data_width-1:0]   sa_b1,
  output logic                    sa_enable,
  output logic                    sa_clr,
  input  logic                    arr_done,
  input  logic [2*data_width-1:0] arr_c00,
  input  logic [2*data_width-1:0] arr_c01,
  input  logic [2*data_width-1:0] arr_c10,
  input  logic [2*data_width-1:0] arr_c11
);

  localparam int unsigned DW = data_width;
  localparam int unsigned CW = 2 * data_width;

  state_e            state_q, state_d;
  logic [1:0]        feed_cnt_q, feed_cnt_d;
  logic              drain_late_q, drain_late_d;
  logic [4*DW-1:0]   a_q, a_d, b_q, b_d;
  logic [DW-1:0]     sa_a0_q, sa_a0_d, sa_a1_q, sa_a1_d;
  logic [DW-1:0]     sa_b0_q, sa_b0_d, sa_b1_q, sa_b1_d;
  logic              sa_enable_q, sa_enable_d, sa_clr_q, sa_clr_d;
  logic [CW-1:0]     c00_q, c00_d, c01_q, c01_d, c10_q, c10_d, c11_q, c11_d;
  logic              out_valid_q, out_valid_d;
  logic              done_ok, leave_drain;

  // done is only trusted from the second DRAIN cycle on: a level left high
  // from a previous job must not trigger an early capture.
  assign done_ok = (state_q == StDrain) && drain_late_q && arr_done;

`ifdef SYSTOLIC_CTRL_TIMEOUT_EN
  localparam int unsigned TW = $clog2(timeout_cycles + 1);
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          tmo_hit;
  logic          err_q, err_d;

  assign tmo_hit     = (state_q == StDrain) && (tmo_cnt_q == TW'(timeout_cycles - 1));
  assign leave_drain = done_ok || tmo_hit;
  assign bus.err     = err_q;
`else
  assign leave_drain = done_ok;
  assign bus.err     = 1'b0;
`endif

  // Element views of the latched job.
  logic [DW-1:0] a00, a01, a10, a11, b00, b01, b10, b11;
  assign a00 = a_q[IDX_00*DW +: DW];
  assign a01 = a_q[IDX_01*DW +: DW];
  assign a10 = a_q[IDX_10*DW +: DW];
  assign a11 = a_q[IDX_11*DW +: DW];
  assign b00 = b_q[IDX_00*DW +: DW];
  assign b01 = b_q[IDX_01*DW +: DW];
  assign b10 = b_q[IDX_10*DW +: DW];
  assign b11 = b_q[IDX_11*DW +: DW];

  always_comb begin
    state_d      = state_q;
    feed_cnt_d   = feed_cnt_q;
    drain_late_d = drain_late_q;
    a_d          = a_q;
    b_d          = b_q;
    c00_d        = c00_q;
    c01_d        = c01_q;
    c10_d        = c10_q;
    c11_d        = c11_q;
    out_valid_d  = out_valid_q;
`ifdef SYSTOLIC_CTRL_TIMEOUT_EN
    tmo_cnt_d    = tmo_cnt_q;
    err_d        = err_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          a_d     = bus.a_mat;
          b_d     = bus.b_mat;
          state_d = StClear;
        end
      end
      StClear: begin
        feed_cnt_d = '0;
        state_d    = StFeed;
      end
      StFeed: begin
        if (feed_cnt_q == 2'(FEED_CYCLES - 1)) begin
          drain_late_d = 1'b0;
`ifdef SYSTOLIC_CTRL_TIMEOUT_EN
          tmo_cnt_d    = '0;
`endif
          state_d      = StDrain;
        end else begin
          feed_cnt_d = feed_cnt_q + 2'd1;
        end
      end
      StDrain: begin
        drain_late_d = 1'b1;
`ifdef SYSTOLIC_CTRL_TIMEOUT_EN
        tmo_cnt_d    = tmo_cnt_q + TW'(1);
`endif
        if (leave_drain) begin
          c00_d       = arr_c00;
          c01_d       = arr_c01;
          c10_d       = arr_c10;
          c11_d       = arr_c11;
          out_valid_d = 1'b1;
`ifdef SYSTOLIC_CTRL_TIMEOUT_EN
          err_d       = !done_ok;
`endif
          state_d     = StOut;
        end
      end
      StOut: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
`ifdef SYSTOLIC_CTRL_TIMEOUT_EN
          err_d       = 1'b0;
`endif
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Array-side outputs are registered from the next state so they line up
    // with the state the controller is in during that cycle.
    sa_a0_d     = '0;
    sa_a1_d     = '0;
    sa_b0_d     = '0;
    sa_b1_d     = '0;
    sa_enable_d = 1'b0;
    sa_clr_d    = 1'b0;
    case (state_d)
      StClear: sa_clr_d = 1'b1;
      StFeed: begin
        sa_enable_d = 1'b1;
        // Row i of A and column j of B are delayed by i / j cycles.
        case (feed_cnt_d)
          2'd0: begin
            sa_a0_d = a00;
            sa_b0_d = b00;
          end
          2'd1: begin
            sa_a0_d = a01;
            sa_a1_d = a10;
            sa_b0_d = b10;
            sa_b1_d = b01;
          end
          2'd2: begin
            sa_a1_d = a11;
            sa_b1_d = b11;
          end
          default: ;
        endcase
      end
      StDrain: sa_enable_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      feed_cnt_q   <= '0;
      drain_late_q <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      sa_a0_q      <= '0;
      sa_a1_q      <= '0;
      sa_b0_q      <= '0;
      sa_b1_q      <= '0;
      sa_enable_q  <= 1'b0;
      sa_clr_q     <= 1'b0;
      c00_q        <= '0;
      c01_q        <= '0;
      c10_q        <= '0;
      c11_q        <= '0;
      out_valid_q  <= 1'b0;
`ifdef SYSTOLIC_CTRL_TIMEOUT_EN
      tmo_cnt_q    <= '0;
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      feed_cnt_q   <= feed_cnt_d;
      drain_late_q <= drain_late_d;
      a_q          <= a_d;
      b_q          <= b_d;
      sa_a0_q      <= sa_a0_d;
      sa_a1_q      <= sa_a1_d;
      sa_b0_q      <= sa_b0_d;
      sa_b1_q      <= sa_b1_d;
      sa_enable_q  <= sa_enable_d;
      sa_clr_q     <= sa_clr_d;
      c00_q        <= c00_d;
      c01_q        <= c01_d;
      c10_q        <= c10_d;
      c11_q        <= c11_d;
      out_valid_q  <= out_valid_d;
`ifdef SYSTOLIC_CTRL_TIMEOUT_EN
      tmo_cnt_q    <= tmo_cnt_d;
      err_q        <= err_d;
`endif
    end
  end

  assign sa_a0         = sa_a0_q;
  assign sa_a1         = sa_a1_q;
  assign sa_b0         = sa_b0_q;
  assign sa_b1         = sa_b1_q;
  assign sa_enable     = sa_enable_q;
  assign sa_clr        = sa_clr_q;
  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = out_valid_q;
  assign bus.c00       = c00_q;
  assign bus.c01       = c01_q;
  assign bus.c10       = c10_q;
  assign bus.c11       = c11_q;

endmodule

// File: tb/tb_systolic_2x2_ctrl.sv
module tb_systolic_2x2_ctrl;
  import systolic_pkg::*;

  localparam int unsigned DW  = 8;
  localparam int          TMO = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  systolic_2x2_ctrl_if #(.data_width(DW)) bus ();

  logic [DW-1:0]   sa_a0, sa_a1, sa_b0, sa_b1;
  logic            sa_enable, sa_clr, arr_done;
  logic [2*DW-1:0] arr_c00, arr_c01, arr_c10, arr_c11;

  systolic_2x2_ctrl #(
    .data_width    (DW),
    .timeout_cycles(TMO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .sa_a0    (sa_a0),
    .sa_a1    (sa_a1),
    .sa_b0    (sa_b0),
    .sa_b1    (sa_b1),
    .sa_enable(sa_enable),
    .sa_clr   (sa_clr),
    .arr_done (arr_done),
    .arr_c00  (arr_c00),
    .arr_c01  (arr_c01),
    .arr_c10  (arr_c10),
    .arr_c11  (arr_c11)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // ---- reference model: plain matrix arithmetic on the packed words ----
  function automatic int el(input logic [31:0] m, input int i, input int k);
    return int'(m[(2*i+k)*8 +: 8]);
  endfunction

  function automatic logic [15:0] cval(input logic [31:0] a, input logic [31:0] b,
                                       input int i, input int j);
    int acc = 0;
    for (int k = 0; k < 2; k++) acc += el(a, i, k) * el(b, k, j);
    return acc[15:0];
  endfunction

  // Row r of A enters r cycles late; column c of B enters c cycles late.
  function automatic int skew_a(input logic [31:0] a, input int r, input int t);
    int k = t - r;
    if (k < 0 || k > 1) return 0;
    return el(a, r, k);
  endfunction

  function automatic int skew_b(input logic [31:0] b, input int c, input int t);
    int k = t - c;
    if (k < 0 || k > 1) return 0;
    return el(b, k, c);
  endfunction

  task automatic drive_arr(input bit prod, input logic [31:0] a, input logic [31:0] b);
    if (prod) begin
      arr_c00 = cval(a, b, 0, 0);
      arr_c01 = cval(a, b, 0, 1);
      arr_c10 = cval(a, b, 1, 0);
      arr_c11 = cval(a, b, 1, 1);
    end else begin
      arr_c00 = 16'($urandom);
      arr_c01 = 16'($urandom);
      arr_c10 = 16'($urandom);
      arr_c11 = 16'($urandom);
    end
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, " in_ready"}, 64'(bus.in_ready), 64'd1);
    chk({tag, " array outs"}, 64'({sa_a0, sa_a1, sa_b0, sa_b1, sa_enable, sa_clr}), 64'd0);
    chk({tag, " out_valid/err"}, 64'({bus.out_valid, bus.err}), 64'd0);
    chk({tag, " results"}, {bus.c00, bus.c01, bus.c10, bus.c11}, 64'd0);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    @(negedge clk);
    check_reset_state(tag);
    rst = 1'b0;
  endtask

  // done_k: DRAIN cycle index at which arr_done pulses (<1 means never usefully)
  // stale : arr_done held high throughout; bp: out_ready-low cycles in OUT
  task automatic run_job(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input int done_k, input bit stale, input int bp,
                         input logic [63:0] exp_c);
    int  cap_k;
    bit  exp_err;
    bit  hang;
    int  last_k;
    cap_k   = stale ? 1 : ((done_k < 1) ? -1 : done_k);
    exp_err = 1'b0;
    hang    = 1'b0;
`ifdef SYSTOLIC_CTRL_TIMEOUT_EN
    if (cap_k < 0 || cap_k > TMO - 1) begin
      cap_k   = TMO - 1;
      exp_err = 1'b1;
    end
`else
    if (cap_k < 0) hang = 1'b1;
`endif
    last_k = hang ? 29 : cap_k;

    arr_done      = stale;
    drive_arr(1'b0, a, b);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.a_mat     = a;
    bus.b_mat     = b;
    chk({tag, " in_ready idle"}, 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    // CLEAR: a competing offer must be ignored
    bus.a_mat = ~a;
    bus.b_mat = ~b;
    chk({tag, " clear"}, 64'({sa_clr, sa_enable, sa_a0, sa_a1, sa_b0, sa_b1}),
        64'({1'b1, 1'b0, 32'd0}));
    chk({tag, " in_ready busy"}, 64'(bus.in_ready), 64'd0);
    for (int t = 0; t < int'(FEED_CYCLES); t++) begin
      @(negedge clk);
      chk($sformatf("%s feed t%0d", tag, t),
          64'({sa_clr, sa_enable, sa_a0, sa_a1, sa_b0, sa_b1}),
          64'({1'b0, 1'b1, 8'(skew_a(a, 0, t)), 8'(skew_a(a, 1, t)),
               8'(skew_b(b, 0, t)), 8'(skew_b(b, 1, t))}));
    end
    bus.in_valid = 1'b0;
    for (int k = 0; k <= last_k; k++) begin
      @(negedge clk);
      chk($sformatf("%s drain k%0d", tag, k),
          64'({sa_clr, sa_enable, sa_a0, sa_a1, sa_b0, sa_b1, bus.out_valid}),
          64'({1'b0, 1'b1, 32'd0, 1'b0}));
      arr_done = stale || (k == done_k);
      drive_arr(k == cap_k, a, b);
    end
    if (hang) begin
      chk({tag, " hang err"}, 64'(bus.err), 64'd0);
      arr_done = 1'b0;
      return;
    end
    @(negedge clk);
    drive_arr(1'b0, a, b);
    for (int i = 0; i <= bp; i++) begin
      chk($sformatf("%s out c i%0d", tag, i), {bus.c00, bus.c01, bus.c10, bus.c11}, exp_c);
      chk($sformatf("%s out flags i%0d", tag, i),
          64'({bus.out_valid, bus.err, bus.in_ready, sa_enable, sa_clr}),
          64'({1'b1, exp_err, 3'b000}));
      bus.out_ready = (i == bp);
      bus.in_valid  = (i < bp);   // offers during OUT must be ignored
      bus.a_mat     = 32'($urandom);
      @(negedge clk);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    arr_done      = 1'b0;
    chk({tag, " after handshake"}, 64'({bus.out_valid, bus.in_ready}), 64'({1'b0, 1'b1}));
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    int          done_k;
    bit          stale;
    int          bp;
    logic [63:0] exp_c;
  } vec_t;

  vec_t vecs[4];

  initial begin
    logic [31:0] ra, rb;
    logic [63:0] rc;

    vecs[0] = '{a: {8'd4, 8'd3, 8'd2, 8'd1}, b: {8'd8, 8'd7, 8'd6, 8'd5}, done_k: 1,
                stale: 1'b0, bp: 0, exp_c: {16'd19, 16'd22, 16'd43, 16'd50}};
    vecs[1] = '{a: {8'd4, 8'd3, 8'd2, 8'd1}, b: {8'd8, 8'd7, 8'd6, 8'd5}, done_k: 1,
                stale: 1'b0, bp: 5, exp_c: {16'd19, 16'd22, 16'd43, 16'd50}};
    vecs[2] = '{a: {4{8'd255}}, b: {4{8'd255}}, done_k: 1, stale: 1'b1, bp: 1,
                exp_c: {4{16'd64514}}};
    vecs[3] = '{a: {8'd0, 8'd1, 8'd1, 8'd0}, b: {8'd6, 8'd7, 8'd8, 8'd9}, done_k: 4,
                stale: 1'b0, bp: 2, exp_c: {16'd7, 16'd6, 16'd9, 16'd8}};

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a_mat     = '0;
    bus.b_mat     = '0;
    arr_done      = 1'b0;
    arr_c00 = '0; arr_c01 = '0; arr_c10 = '0; arr_c11 = '0;
    @(negedge clk);
    do_reset("reset");

    for (int v = 0; v < 4; v++)
      run_job($sformatf("vec%0d", v), vecs[v].a, vecs[v].b, vecs[v].done_k,
              vecs[v].stale, vecs[v].bp, vecs[v].exp_c);

    // Reset in the middle of FEED (t=1), then a full job.
    bus.in_valid = 1'b1;
    bus.a_mat    = vecs[3].a;
    bus.b_mat    = vecs[3].b;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("midfeed pre t1 a1", 64'(sa_a1), 64'd1);
    do_reset("midfeed reset");
    run_job("post midfeed", vecs[0].a, vecs[0].b, 2, 1'b0, 0, vecs[0].exp_c);

    // Reset in the middle of DRAIN.
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("middrain pre enable", 64'(sa_enable), 64'd1);
    do_reset("middrain reset");

    // Random jobs checked against the arithmetic model.
    for (int n = 0; n < 16; n++) begin
      ra = $urandom;
      rb = $urandom;
      rc = {cval(ra, rb, 0, 0), cval(ra, rb, 0, 1), cval(ra, rb, 1, 0), cval(ra, rb, 1, 1)};
      run_job($sformatf("rand%0d", n), ra, rb, int'($urandom_range(1, 6)),
              ($urandom_range(0, 5) == 0), int'($urandom_range(0, 3)), rc);
    end

    // arr_done only pulses in the ignored first DRAIN cycle: timeout or wait forever.
    ra = $urandom;
    rb = $urandom;
    rc = {cval(ra, rb, 0, 0), cval(ra, rb, 0, 1), cval(ra, rb, 1, 0), cval(ra, rb, 1, 1)};
    run_job("nodone", ra, rb, 0, 1'b0, 1, rc);
    do_reset("final reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/systolic_2x2_ctrl.md
SYSTOLIC_2X2_CTRL -- requirements
Module: systolic_2x2_ctrl

Interface
REQ-001 Parameter data_width, default 8, operand width; result width is 2*data_width.
REQ-002 Parameter timeout_cycles, default 16, DRAIN watchdog limit; used only when SYSTOLIC_CTRL_TIMEOUT_EN is defined.
REQ-003 Port clk  input  1  single clock; all logic on rising edge.
REQ-004 Port rst  input  1  reset, synchronous and active-high.
REQ-005 Port in_valid  input  1  job offered.
REQ-006 Port in_ready  output  1  job accepted when in_valid and in_ready are both high.
REQ-007 Port a_mat  input  4*data_width  matrix A, A[i][k] at bits [(2i+k)*data_width +: data_width].
REQ-008 Port b_mat  input  4*data_width  matrix B, same packing as A.
REQ-009 Ports sa_a0, sa_a1, sa_b0, sa_b1  output  data_width each  registered skewed operands to the 2x2 array.
REQ-010 Port sa_enable  output  1  array enable.
REQ-011 Port sa_clr  output  1  one-cycle accumulator clear to the array.
REQ-012 Port arr_done  input  1  array completion flag.
REQ-013 Ports arr_c00, arr_c01, arr_c10, arr_c11  input  2*data_width each  array results.
REQ-014 Ports c00, c01, c10, c11  output  2*data_width each  captured results.
REQ-015 Port out_valid  output  1  results available; Port out_ready  input  1  consumer accepts.
REQ-016 Port err  output  1  timeout flag, qualified by out_valid.

Function
REQ-017 The FSM SHALL have states IDLE, CLEAR, FEED, DRAIN and OUT; in_ready SHALL be 1 only in IDLE.
REQ-018 A handshake in IDLE SHALL latch a_mat and b_mat and move to CLEAR; in_valid outside IDLE SHALL be ignored.
REQ-019 CLEAR SHALL last exactly 1 cycle with sa_clr=1, sa_enable=0 and all operands 0, then move to FEED.
REQ-020 FEED SHALL last exactly 3 cycles (t=0,1,2) with sa_enable=1.
REQ-021 During FEED, sa_a0 SHALL be A00, A01, 0 and sa_a1 SHALL be 0, A10, A11 for t=0,1,2.
REQ-022 During FEED, sa_b0 SHALL be B00, B10, 0 and sa_b1 SHALL be 0, B01, B11 for t=0,1,2.
REQ-023 DRAIN SHALL hold sa_enable=1 with all operands 0.
REQ-024 arr_done SHALL be ignored in CLEAR and FEED, and in the first DRAIN cycle.
REQ-025 From the second DRAIN cycle, arr_done=1 SHALL capture arr_c* into c*, set out_valid and move to OUT.
REQ-026 In OUT, sa_enable SHALL be 0, and c*, err and out_valid SHALL stay stable until out_ready=1.
REQ-027 The out_valid and out_ready handshake SHALL clear out_valid and return to IDLE; a new job SHALL be accepted no earlier than the following cycle.
REQ-028 Results SHALL pass through unmodified; any wrap from overflow belongs to the array.

Reset
REQ-029 rst SHALL force IDLE from any state, including mid-FEED and mid-DRAIN, and discard the latched job.
REQ-030 rst SHALL zero sa_a*, sa_b*, sa_enable, sa_clr, c*, out_valid and err, and set in_ready=1 on the first cycle after reset.

Configuration
REQ-031 With SYSTOLIC_CTRL_TIMEOUT_EN defined, a counter SHALL run in DRAIN.
REQ-032 If arr_done has not been seen after timeout_cycles DRAIN cycles, the block SHALL set err=1, capture arr_c* anyway, set out_valid and enter OUT.
REQ-033 Without the macro, DRAIN SHALL wait indefinitely, no counter logic SHALL be built, and err SHALL be tied to 0.

Structure
REQ-034 Package systolic_pkg SHALL hold the state enumeration, FEED_CYCLES=3 and the operand packing index helper constants.
REQ-035 No sub-module is required; the FSM, feed counter and capture registers SHALL be a single module.

Verification
REQ-036 Job A=[[1,2],[3,4]], B=[[5,6],[7,8]] -> FEED gives sa_a0 1,2,0; sa_a1 0,3,4; sa_b0 5,7,0; sa_b1 0,6,8. Model arr_done 2 cycles after FEED with arr_c* = 19, 22, 43, 50 -> c* = 19, 22, 43, 50 and err=0.
REQ-037 Backpressure: out_ready held low for 5 cycles in OUT -> out_valid=1 and c* stable throughout, in_ready=0, second in_valid ignored; a new job is accepted the cycle after the handshake.
REQ-038 rst asserted at FEED t=1 -> next cycle IDLE, all outputs 0, in_ready=1; a new job then completes correctly.
REQ-039 arr_done held high throughout (stale) -> no capture before the second DRAIN cycle; sa_clr pulses exactly once per job.
REQ-040 With the macro and arr_done never asserted -> after 16 DRAIN cycles out_valid=1 and err=1. Without the macro -> the block stays in DRAIN and err=0.
